// File: rtl/stack_instr_sequencer.sv
// Thumb SP/stack-group decoder and sequencer feeding ST_controller.
// Ports: clk, resetn (async low), instr_valid/instr_ready/instr from fetch;
//   op_sel, RL, Rd0, Rd1, imm_off, ST_Wen to ST_controller; st_busy, st_done.
// Option: EMPTY_RL_SKIP_EN turns PUSH/POP with an empty list into a NOP.
module stack_instr_sequencer #(
    parameter int IW        = 16,
    parameter int PP_CYCLES = 11,
    parameter int CNT_W     = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [IW-1:0] instr,
    output logic [7:0]    op_sel,
    output logic [8:0]    RL,
    output logic [2:0]    Rd0,
    output logic [2:0]    Rd1,
    output logic [15:0]   imm_off,
    output logic          ST_Wen,
    output logic          st_busy,
    output logic          st_done
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_EXEC = 1'b1;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_PUSH  = 8'h01;
    localparam logic [7:0] OP_POP   = 8'h02;
    localparam logic [7:0] OP_ADDSP = 8'h04;
    localparam logic [7:0] OP_SUBSP = 8'h08;
    localparam logic [7:0] OP_MOVSP = 8'h10;
    localparam logic [7:0] OP_ADDS  = 8'h20;
    localparam logic [7:0] OP_LDRSP = 8'h40;
    localparam logic [7:0] OP_STRSP = 8'h80;

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_op;
    logic [8:0]       r_rl;
    logic [2:0]       r_rd0;
    logic [2:0]       r_rd1;
    logic [15:0]      r_imm;
    logic             r_wen;
    logic             r_busy;
    logic             r_done;

    logic [7:0]  w_op;
    logic [8:0]  w_rl;
    logic [2:0]  w_rd0;
    logic [2:0]  w_rd1;
    logic [15:0] w_imm;
    logic        w_pp;
    logic        w_stack;
    logic        w_accept;
    logic        w_last;

    // Encodings below are mutually exclusive, so a parallel decode is safe.
    always_comb begin
        w_op  = OP_NOP;
        w_rl  = '0;
        w_rd0 = '0;
        w_rd1 = '0;
        w_imm = '0;
        unique case (1'b1)
            (instr[15:9] == 7'b1011010): begin
                w_op = OP_PUSH;
                w_rl = instr[8:0];
            end
            (instr[15:9] == 7'b1011110): begin
                w_op = OP_POP;
                w_rl = instr[8:0];
            end
            (instr[15:7] == 9'b101100000): begin
                w_op  = OP_ADDSP;
                w_imm = {7'd0, instr[6:0], 2'b00};
            end
            (instr[15:7] == 9'b101100001): begin
                w_op  = OP_SUBSP;
                w_imm = {7'd0, instr[6:0], 2'b00};
            end
            (instr[15:11] == 5'b10101): begin
                w_op  = OP_ADDS;
                w_rd1 = instr[10:8];
                w_imm = {6'd0, instr[7:0], 2'b00};
            end
            (instr[15:11] == 5'b10011): begin
                w_op  = OP_LDRSP;
                w_rd1 = instr[10:8];
                w_imm = {6'd0, instr[7:0], 2'b00};
            end
            (instr[15:11] == 5'b10010): begin
                w_op  = OP_STRSP;
                w_rd1 = instr[10:8];
                w_imm = {6'd0, instr[7:0], 2'b00};
            end
            (instr[15:7] == 9'b010001100 &&
             instr[6:3] == 4'b1101): begin
                w_op  = OP_MOVSP;
                w_rd0 = instr[2:0];
            end
            default: ;
        endcase
        w_pp = (w_op == OP_PUSH) || (w_op == OP_POP);
`ifdef EMPTY_RL_SKIP_EN
        if (w_pp && (w_rl == 9'd0)) begin
            w_op = OP_NOP;
            w_pp = 1'b0;
        end
`endif
    end

    assign w_stack     = (w_op != OP_NOP);
    assign w_last      = (r_state == S_EXEC) && (r_cnt == '0);
    assign instr_ready = (r_state == S_IDLE) || w_last;
    assign w_accept    = instr_valid && instr_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= OP_NOP;
            r_rl    <= '0;
            r_rd0   <= '0;
            r_rd1   <= '0;
            r_imm   <= '0;
            r_wen   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (w_accept && w_stack) begin
            // Load from IDLE or chain straight out of a final cycle.
            r_state <= S_EXEC;
            r_cnt   <= w_pp ? CNT_W'(PP_CYCLES - 1) : '0;
            r_op    <= w_op;
            r_rl    <= w_rl;
            r_rd0   <= w_rd0;
            r_rd1   <= w_rd1;
            r_imm   <= w_imm;
            r_wen   <= 1'b1;
            r_busy  <= 1'b1;
            r_done  <= !w_pp;
        end else if ((r_state == S_EXEC) && (r_cnt != '0)) begin
            r_cnt  <= r_cnt - CNT_W'(1);
            r_done <= (r_cnt == CNT_W'(1));
        end else begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= OP_NOP;
            r_rl    <= '0;
            r_rd0   <= '0;
            r_rd1   <= '0;
            r_imm   <= '0;
            r_wen   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end
    end

    assign op_sel  = r_op;
    assign RL      = r_rl;
    assign Rd0     = r_rd0;
    assign Rd1     = r_rd1;
    assign imm_off = r_imm;
    assign ST_Wen  = r_wen;
    assign st_busy = r_busy;
    assign st_done = r_done;

endmodule
